switch_reader: RTL and testbench

SWITCH_READER -- requirements
Module: switch_reader

---
 rtl/switch_reader.sv | 151 +++++++++++++++
 tb/tb_switch_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_reader.sv
// switch_reader: synchronizes and debounces a 24-bit board switch bank,
// tracks which switches changed and how many accepted updates occurred,
// and exposes everything through a small request/acknowledge read port.
// Optional build macro SW_CHG_IRQ_EN adds a registered change interrupt;
// without it chg_irq is tied low and no interrupt logic exists.
module switch_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter logic [31:0] ID_WORD         = 32'h5357_0001
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic [23:0] device_sw,
    input  logic        rd_req,
    input  logic [1:0]  rd_addr,
    output logic        rd_ack,
    output logic [31:0] rd_data,
    output logic [23:0] sw_stable,
    output logic        chg_irq
);

    // Counter value that marks a candidate as having been stable long enough
    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } readState_t;

    logic [23:0] r_syncMeta;
    logic [23:0] r_syncSw;
    logic [23:0] r_candidate;
    logic [15:0] r_count;
    logic [23:0] r_swStable;
    logic [23:0] r_chgFlags;
    logic [31:0] r_evtCnt;
    readState_t  r_state;
    logic [1:0]  r_addr;
    logic        r_ack;

    logic        w_update;
    logic [23:0] w_setBits;
    logic        w_clearFlags;
    logic [31:0] w_readMux;

    // A new vector is accepted once the candidate has been stable for the full window
    assign w_update     = (r_count == CNT_MAX) && (r_candidate != r_swStable);
    assign w_setBits    = w_update ? (r_candidate ^ r_swStable) : 24'h0;
    assign w_clearFlags = (r_state == ACK) && (r_addr == 2'd1);

    // Two-flop synchronizer; only the second stage feeds the debouncer
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_syncMeta <= 24'h0;
            r_syncSw   <= 24'h0;
        end else begin
            r_syncMeta <= device_sw;
            r_syncSw   <= r_syncMeta;
        end
    end

    // Candidate tracks the synchronized input; the counter measures how long it has held
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_candidate <= 24'h0;
            r_count     <= 16'h0;
        end else if (r_syncSw != r_candidate) begin
            r_candidate <= r_syncSw;
            r_count     <= 16'h0;
        end else if (r_count != CNT_MAX) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Accepted vector, sticky change flags (read-to-clear, set wins) and update count
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_swStable <= 24'h0;
            r_chgFlags <= 24'h0;
            r_evtCnt   <= 32'h0;
        end else begin
            r_chgFlags <= (w_clearFlags ? 24'h0 : r_chgFlags) | w_setBits;
            if (w_update) begin
                r_swStable <= r_candidate;
                r_evtCnt   <= r_evtCnt + 32'd1;
            end
        end
    end

    // Read FSM: accept a request in IDLE, acknowledge for exactly one cycle, drop requests seen during ACK
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= 2'd0;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rd_req) begin
                        r_state <= ACK;
                        r_addr  <= rd_addr;
                        r_ack   <= 1'b1;
                    end else begin
                        r_ack <= 1'b0;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // Register map selection; live values so a flag read shows exactly what the clear removes
    always_comb begin
        w_readMux = 32'h0;
        case (r_addr)
            2'd0:    w_readMux = {8'h00, r_swStable};
            2'd1:    w_readMux = {8'h00, r_chgFlags};
            2'd2:    w_readMux = r_evtCnt;
            default: w_readMux = ID_WORD;
        endcase
    end

    // Outputs are forced quiet while reset is held so a read in flight is aborted immediately
    assign rd_ack    = r_ack & ~rst;
    assign rd_data   = (r_ack && !rst) ? w_readMux : 32'h0;
    assign sw_stable = r_swStable;

`ifdef SW_CHG_IRQ_EN
    logic r_irq;

    // Level interrupt: registered OR of the change flags, one cycle behind them
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_chgFlags;
        end
    end

    assign chg_irq = r_irq & ~rst;
`else
    assign chg_irq = 1'b0;
`endif

endmodule

// File: tb/tb_switch_reader.sv
// tb_switch_reader: directed and randomized checks of switch_reader with a
// short debounce window, compared against a history-window reference model.
module tb_switch_reader;

   localparam int          D  = 4;
   localparam logic [31:0] ID = 32'h5357_0001;

   logic        clk_i = 1'b0;
   logic        rst;
   logic [23:0] device_sw;
   logic        rd_req;
   logic [1:0]  rd_addr;
   logic        rd_ack;
   logic [31:0] rd_data;
   logic [23:0] sw_stable;
   logic        chg_irq;

   int checks = 0;
   int errors = 0;

   // Reference model state: a vector is accepted when the last D synchronized samples agree
   logic [23:0] mPipe1, mPipe2;
   logic [23:0] mHist[$];
   logic [23:0] mStable, mFlags;
   logic [31:0] mEvt;
   bit          mAck;
   logic [1:0]  mAddr;
   bit          mIrq;

   logic        ackSeen;
   logic [31:0] dataSeen;
   logic [23:0] curSw;

   switch_reader #(
      .DEBOUNCE_CYCLES(D),
      .ID_WORD(ID)
   ) dut (
      .clk_i(clk_i),
      .rst(rst),
      .device_sw(device_sw),
      .rd_req(rd_req),
      .rd_addr(rd_addr),
      .rd_ack(rd_ack),
      .rd_data(rd_data),
      .sw_stable(sw_stable),
      .chg_irq(chg_irq)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [1:0] a);
      case (a)
         2'd0:    return {8'h00, mStable};
         2'd1:    return {8'h00, mFlags};
         2'd2:    return mEvt;
         default: return ID;
      endcase
   endfunction

   task automatic modelEdge();
      logic [23:0] setBits;
      bit allSame;
      setBits = 24'h0;
      if (rst) begin
         mPipe1 = 24'h0; mPipe2 = 24'h0;
         mHist = {};
         mHist.push_back(24'h0);
         mStable = 24'h0; mFlags = 24'h0; mEvt = 32'h0;
         mAck = 1'b0; mAddr = 2'd0; mIrq = 1'b0;
      end else begin
         if (mHist.size() >= D) begin
            allSame = 1'b1;
            foreach (mHist[k]) if (mHist[k] != mHist[$]) allSame = 1'b0;
            if (allSame && mHist[$] != mStable) begin
               setBits = mHist[$] ^ mStable;
               mStable = mHist[$];
               mEvt    = mEvt + 32'd1;
            end
         end
         mIrq   = |mFlags;
         mFlags = ((mAck && mAddr == 2'd1) ? 24'h0 : mFlags) | setBits;
         mHist.push_back(mPipe2);
         if (mHist.size() > D) void'(mHist.pop_front());
         mPipe2 = mPipe1;
         mPipe1 = device_sw;
         if (mAck) begin
            mAck = 1'b0;
         end else if (rd_req) begin
            mAck  = 1'b1;
            mAddr = rd_addr;
         end
      end
   endtask

   task automatic checkOutput();
      logic        expAck;
      logic [31:0] expData;
      logic        expIrq;
      expAck  = mAck && !rst;
      expData = expAck ? modelRead(mAddr) : 32'h0;
`ifdef SW_CHG_IRQ_EN
      expIrq  = mIrq && !rst;
`else
      expIrq  = 1'b0;
`endif
      checkVal("rd_ack", 32'(rd_ack), 32'(expAck));
      checkVal("rd_data", rd_data, expData);
      checkVal("sw_stable", {8'h00, sw_stable}, {8'h00, mStable});
      checkVal("chg_irq", 32'(chg_irq), 32'(expIrq));
   endtask

   task automatic tick();
      @(posedge clk_i);
      modelEdge();
      #1;
      checkOutput();
   endtask

   task automatic applyStimulus(input logic [23:0] sw, input logic req, input logic [1:0] addr);
      device_sw = sw;
      rd_req    = req;
      rd_addr   = addr;
      tick();
   endtask

   task automatic readReg(input logic [1:0] a, output logic ack, output logic [31:0] data);
      applyStimulus(device_sw, 1'b1, a);
      ack  = rd_ack;
      data = rd_data;
      applyStimulus(device_sw, 1'b0, a);
   endtask

   initial begin
      rst = 1'b1; device_sw = 24'h0; rd_req = 1'b0; rd_addr = 2'd0;
      applyStimulus(24'h0, 1'b0, 2'd0);
      applyStimulus(24'h0, 1'b0, 2'd0);
      checkVal("reset_ack", 32'(rd_ack), 32'h0);
      checkVal("reset_data", rd_data, 32'h0);
      checkVal("reset_stable", {8'h00, sw_stable}, 32'h0);
      checkVal("reset_irq", 32'(chg_irq), 32'h0);

      rst = 1'b0;
      for (int i = 0; i < 6; i++) applyStimulus(24'h00000F, 1'b0, 2'd0);
      checkVal("debounce_not_yet", {8'h00, sw_stable}, 32'h0);
      applyStimulus(24'h00000F, 1'b0, 2'd0);
      checkVal("debounce_accept", {8'h00, sw_stable}, 32'h0000000F);

      for (int i = 0; i < 3; i++) applyStimulus(24'h00002F, 1'b0, 2'd0);
      for (int i = 0; i < 10; i++) applyStimulus(24'h00000F, 1'b0, 2'd0);
      checkVal("glitch_stable", {8'h00, sw_stable}, 32'h0000000F);
      readReg(2'd2, ackSeen, dataSeen);
      checkVal("glitch_evt_ack", 32'(ackSeen), 32'h1);
      checkVal("glitch_evt", dataSeen, 32'h1);
`ifdef SW_CHG_IRQ_EN
      checkVal("irq_set", 32'(chg_irq), 32'h1);
`else
      checkVal("irq_tied", 32'(chg_irq), 32'h0);
`endif

      readReg(2'd1, ackSeen, dataSeen);
      checkVal("flags_read", dataSeen, 32'h0000000F);
      readReg(2'd1, ackSeen, dataSeen);
      checkVal("flags_reread", dataSeen, 32'h0);
      checkVal("irq_after_clear", 32'(chg_irq), 32'h0);

      for (int i = 0; i < 5; i++) applyStimulus(24'h00010F, 1'b0, 2'd0);
      applyStimulus(24'h00010F, 1'b1, 2'd1);
      checkVal("race_ack", 32'(rd_ack), 32'h1);
      checkVal("race_pre_clear", rd_data, 32'h0);
      applyStimulus(24'h00010F, 1'b0, 2'd1);
      readReg(2'd1, ackSeen, dataSeen);
      checkVal("race_set_wins", dataSeen, 32'h00000100);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(24'h00010F, 1'b1, 2'd3);
         checkVal("held_req_ack", 32'(rd_ack), (i % 2 == 0) ? 32'h1 : 32'h0);
         checkVal("held_req_data", rd_data, (i % 2 == 0) ? ID : 32'h0);
      end
      applyStimulus(24'h00010F, 1'b0, 2'd0);

      applyStimulus(24'h000000, 1'b0, 2'd0);
      for (int i = 0; i < 8; i++) applyStimulus(24'h000000, 1'b0, 2'd0);
      for (int i = 0; i < 9; i++) applyStimulus(24'h000ABC, 1'b0, 2'd0);
      for (int i = 0; i < 9; i++) applyStimulus(24'h000123, 1'b0, 2'd0);
      for (int i = 0; i < 9; i++) applyStimulus(24'hFFFFFF, 1'b0, 2'd0);
      for (int i = 0; i < 9; i++) applyStimulus(24'h5A5A5A, 1'b0, 2'd0);
      readReg(2'd2, ackSeen, dataSeen);
      checkVal("evt_seven", dataSeen, 32'h7);

      applyStimulus(24'h5A5A5A, 1'b1, 2'd2);
      checkVal("abort_pre_ack", 32'(rd_ack), 32'h1);
      rst = 1'b1;
      #1;
      checkVal("abort_ack", 32'(rd_ack), 32'h0);
      checkVal("abort_data", rd_data, 32'h0);
      applyStimulus(24'h000003, 1'b0, 2'd0);
      applyStimulus(24'h000003, 1'b0, 2'd0);
      rst = 1'b0;
      readReg(2'd0, ackSeen, dataSeen);
      checkVal("post_rst_stable", dataSeen, 32'h0);
      readReg(2'd1, ackSeen, dataSeen);
      checkVal("post_rst_flags", dataSeen, 32'h0);
      readReg(2'd2, ackSeen, dataSeen);
      checkVal("post_rst_evt", dataSeen, 32'h0);
      applyStimulus(24'h000003, 1'b0, 2'd0);
      checkVal("post_rst_change", {8'h00, sw_stable}, 32'h00000003);
      readReg(2'd2, ackSeen, dataSeen);
      checkVal("post_rst_evt_one", dataSeen, 32'h1);
      readReg(2'd1, ackSeen, dataSeen);
      checkVal("post_rst_flags_set", dataSeen, 32'h3);

      curSw = 24'h000003;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 2) == 0) curSw = 24'($urandom());
            else curSw = curSw ^ (24'h1 << $urandom_range(0, 23));
         end
         rst = ($urandom_range(0, 199) == 0);
         applyStimulus(curSw, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      rst = 1'b0;
      applyStimulus(curSw, 1'b0, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
